// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle req/ack clock-domain-crossing handshake.
//   state_e             : source-side FSM state encoding
//   DEFAULT_SYNC_STAGES : default synchronizer depth on the crossing signal
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_edge.sv
// Level synchronizer with toggle detection for a 2-phase handshake signal.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   async_i : level from the other clock domain
//   sync_o  : synchronized level (last synchronizer stage)
//   edge_o  : one-cycle pulse for every toggle of async_i
module cdc_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_d, sync_q;
  logic              hist_d, hist_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  // History flop lags the last stage by one cycle, so XOR flags exactly one cycle per toggle.
  assign edge_o = sync_q[STAGES-1] ^ hist_q;

endmodule

// File: rtl/cdc_src.sv
// Transmit end of a 2-phase toggle req/ack clock-domain crossing.
//   clk_i, rst_ni : source-domain clock, asynchronous active-low reset
//   valid_i       : producer has a word on data_i
//   data_i        : word to transfer
//   ready_o       : a word can be accepted this cycle (FSM idle)
//   async_req_o   : request toggle, one per accepted word
//   async_data_o  : word held stable for the destination domain
//   async_ack_i   : acknowledge toggle from the destination domain
//   busy_o        : transfer in flight
//   err_o         : sticky, set when an ack toggle arrives while idle
module cdc_src
  import cdc_pkg::*;
#(
  parameter type         T           = logic,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  T     data_i,
  output logic ready_o,
  output logic async_req_o,
  output T     async_data_o,
  input  logic async_ack_i,
  output logic busy_o,
  output logic err_o
);

  state_e state_d, state_q;
  logic   req_d, req_q;
  T       data_d, data_q;
  logic   busy_d, busy_q;
  logic   err_d, err_q;
  logic   ack_edge;

  cdc_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (async_ack_i),
    .sync_o  (),
    .edge_o  (ack_edge)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // An ack toggle with no outstanding request is a protocol violation.
        if (ack_edge) begin
          err_d = 1'b1;
        end
        if (valid_i) begin
          data_d  = data_i;
          req_d   = ~req_q;
          busy_d  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Data and req stay frozen until the matching ack toggle.
        if (ack_edge) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cdc_src.sv
// Self-checking bench for cdc_src with 8-bit words and two ack synchronizer stages.
module tb_cdc_src;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       async_req_o;
  logic [7:0] async_data_o;
  logic       async_ack_i;
  logic       busy_o;
  logic       err_o;

  logic       tb_ack;
  logic       use_rx;

  // Behavioural receiver in a 7/3 slower clock domain.
  logic       rx_clk = 1'b0;
  logic       rx_rst_n;
  logic [1:0] rx_sync;
  logic       rx_hist;
  logic       rx_ack;
  logic [7:0] rx_q[$];

  int checks   = 0;
  int failures = 0;

  always #3 clk_i = ~clk_i;
  always #7 rx_clk = ~rx_clk;

  assign async_ack_i = use_rx ? rx_ack : tb_ack;

  cdc_src #(
    .T           (logic [7:0]),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .async_req_o  (async_req_o),
    .async_data_o (async_data_o),
    .async_ack_i  (async_ack_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_sync <= 2'b00;
      rx_hist <= 1'b0;
      rx_ack  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], async_req_o};
      rx_hist <= rx_sync[1];
      if (rx_sync[1] ^ rx_hist) begin
        rx_q.push_back(async_data_o);
        rx_ack <= ~rx_ack;
      end
    end
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       exp_ready;
    logic       exp_req;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!ready_o && n < budget) begin
      step();
      n++;
    end
    check(name, {31'd0, ready_o}, 32'd1);
  endtask

  task automatic check_outs(input string name, input logic rdy, input logic req,
                            input logic [7:0] dat, input logic bsy, input logic er);
    check({name, ".ready"}, {31'd0, ready_o}, {31'd0, rdy});
    check({name, ".req"}, {31'd0, async_req_o}, {31'd0, req});
    check({name, ".data"}, {24'd0, async_data_o}, {24'd0, dat});
    check({name, ".busy"}, {31'd0, busy_o}, {31'd0, bsy});
    check({name, ".err"}, {31'd0, err_o}, {31'd0, er});
  endtask

  initial begin
    logic [7:0] words[3];
    logic       exp_req;

    rst_ni   = 1'b0;
    rx_rst_n = 1'b0;
    valid_i  = 1'b0;
    data_i   = 8'h00;
    tb_ack   = 1'b0;
    use_rx   = 1'b0;

    //              valid data   ack  rdy  req  data   busy err
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};

    #10;
    check_outs("in_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs($sformatf("idle%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Single transfers with hand-driven ack, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      valid_i = vecs[i].valid;
      data_i  = vecs[i].data;
      tb_ack  = vecs[i].ack;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_req,
                 vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_err);
    end
    valid_i = 1'b0;

    // Three words against the receiver model, valid held high throughout.
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    rx_q.delete();
    use_rx   = 1'b1;
    rx_rst_n = 1'b1;
    exp_req  = 1'b0;
    valid_i  = 1'b1;
    for (int w = 0; w < 3; w++) begin
      data_i = words[w];
      wait_ready($sformatf("rx_ready%0d", w), 200);
      step();
      exp_req = ~exp_req;
      check($sformatf("rx_req%0d", w), {31'd0, async_req_o}, {31'd0, exp_req});
      if (w < 2) data_i = words[w+1];
      for (int n = 0; n < 200 && !ready_o; n++) begin
        check($sformatf("rx_stable%0d", w), {24'd0, async_data_o}, {24'd0, words[w]});
        step();
      end
    end
    valid_i = 1'b0;
    wait_ready("rx_done", 200);
    check("rx_count", rx_q.size(), 32'd3);
    for (int w = 0; w < 3; w++) begin
      if (w < rx_q.size()) check($sformatf("rx_word%0d", w), {24'd0, rx_q[w]}, {24'd0, words[w]});
    end

    // Stray ack toggle while idle: hand ack back to the bench at the same level.
    tb_ack   = rx_ack;
    use_rx   = 1'b0;
    rx_rst_n = 1'b0;
    step();
    tb_ack = ~tb_ack;
    step();
    check("err_s1", {31'd0, err_o}, 32'd0);
    step();
    check("err_s2", {31'd0, err_o}, 32'd0);
    step();
    check("err_s3", {31'd0, err_o}, 32'd1);
    check("err_ready", {31'd0, ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("err_sticky", {31'd0, err_o}, 32'd1);
    end
    valid_i = 1'b1;
    data_i  = 8'h77;
    step();
    valid_i = 1'b0;
    check_outs("err_xfer", 1'b0, ~exp_req, 8'h77, 1'b1, 1'b1);
    tb_ack = ~tb_ack;
    wait_ready("err_xfer_done", 10);
    check("err_xfer_busy", {31'd0, busy_o}, 32'd0);
    check("err_xfer_err", {31'd0, err_o}, 32'd1);

    // Hold while waiting: data_i changes must not leak through.
    exp_req = async_req_o;
    valid_i = 1'b1;
    data_i  = 8'hA5;
    step();
    exp_req = ~exp_req;
    data_i  = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step();
      check_outs($sformatf("hold%0d", i), 1'b0, exp_req, 8'hA5, 1'b1, 1'b1);
    end

    // Reset mid-transfer.
    #1;
    rst_ni   = 1'b0;
    rx_rst_n = 1'b0;
    tb_ack   = 1'b0;
    valid_i  = 1'b0;
    #1;
    check_outs("mid_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    check_outs("post_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    rx_q.delete();
    use_rx   = 1'b1;
    rx_rst_n = 1'b1;
    valid_i  = 1'b1;
    data_i   = 8'h3C;
    step();
    valid_i  = 1'b0;
    check_outs("fresh_xfer", 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    wait_ready("fresh_done", 200);
    check("fresh_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("fresh_word", {24'd0, rx_q[0]}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
